// File: rtl/mips_pkg.sv
// Shared fetch-path definitions for the MIPS core:
// PC-select codes, vectors, fetch states and buffer entries.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;
  localparam logic [1:0] PCSEL_EXC = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Redirect destination, forced word-aligned.
  function automatic logic [31:0] redir_target(
    input logic [1:0]  sel,
    input logic [31:0] br,
    input logic [31:0] jmp
  );
    logic [31:0] t;
    t = EXC_VECTOR;
    unique case (1'b1)
      sel == PCSEL_BR:  t = br;
      sel == PCSEL_JMP: t = jmp;
      default:          t = EXC_VECTOR;
    endcase
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs
// between instruction memory and decode.
module fetch_buffer
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         hd;
  logic         wp;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && (count != 2'd2);
  assign wp      = hd ^ count[0];
  assign head    = mem[hd];

  // Storage, head pointer and occupancy; flush empties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      hd     <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (do_push) mem[wp] <= din;
      if (do_pop)  hd <= ~hd;
      count <= count + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing,
// imem req/ack handshake, redirect drain, fetch buffer.
module fetch_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [1:0]  pc_mux_sel
);

  fetch_state_t state, state_n;
  logic [31:0]  pc_n;
  logic [31:0]  drain_addr, drain_addr_n;
  logic         busy, busy_n;
  logic         redir;
  logic         ack;
  logic         push;
  logic         flush;
  logic [1:0]   count;
  fetch_entry_t din;
  fetch_entry_t head;

  assign din = '{pc: pc, instr: imem_rdata};

  fetch_buffer u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (instr_ready),
    .flush   (flush),
    .din     (din),
    .head    (head),
    .count   (count)
  );

  assign instr_valid = (count != 2'd0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  // State, PC, outstanding-request flag, drain address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_BOOT;
      pc         <= RESET_VECTOR;
      busy       <= 1'b0;
      drain_addr <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      busy       <= busy_n;
      drain_addr <= drain_addr_n;
    end
  end

  // Request generation, redirect/ack handling, next state.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    busy_n       = busy;
    drain_addr_n = drain_addr;
    imem_req     = 1'b0;
    imem_addr    = pc;
    pc_mux_sel   = PCSEL_SEQ;
    push         = 1'b0;
    flush        = 1'b0;
    redir        = redirect_valid
                && (redirect_sel != PCSEL_SEQ);

    unique case (state)
      ST_BOOT: state_n = ST_FETCH;
      ST_FETCH: begin
        imem_req = busy || (count < 2'd2);
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
      end
      default: state_n = ST_BOOT;
    endcase

    ack = imem_req && imem_ack;

    if (state != ST_BOOT) begin
      if (redir) begin
        flush      = 1'b1;
        pc_mux_sel = redirect_sel;
        pc_n       = redir_target(redirect_sel,
                       branch_target, jump_target);
        if (ack) begin
          state_n = ST_FETCH;
          busy_n  = 1'b0;
        end else if (imem_req) begin
          state_n      = ST_DRAIN;
          busy_n       = 1'b1;
          drain_addr_n = imem_addr;
        end
      end else if (ack) begin
        if (state == ST_FETCH) begin
          push = 1'b1;
          pc_n = pc + 32'd4;
        end
        state_n = ST_FETCH;
        busy_n  = 1'b0;
      end else begin
        busy_n = imem_req;
      end
    end
  end

endmodule
